// File: rtl/iic_reg_seq_pkg.sv
// Shared definitions for the table-driven I2C register sequencer:
// FSM state encoding, table entry layout and watchdog length.
package iic_reg_seq_pkg;

    typedef enum logic [3:0] {
        ST_PWRUP,
        ST_FETCH,
        ST_DECODE,
        ST_WR_TRIG,
        ST_WR_WAIT,
        ST_RD_TRIG,
        ST_RD_WAIT,
        ST_CHECK,
        ST_DLY,
        ST_NEXT,
        ST_DONE,
        ST_ERR
    } seq_state_t;

    // Register address value that marks a table entry as a pure delay.
    localparam logic [15:0] DELAY_MARK = 16'hFFFF;

    localparam int unsigned WDOG_CYCLES = 1024;
    localparam int unsigned WDOG_W      = $clog2(WDOG_CYCLES) + 1;

    function automatic logic [15:0] entry_addr(input logic [23:0] entry);
        return entry[23:8];
    endfunction

    function automatic logic [7:0] entry_data(input logic [23:0] entry);
        return entry[7:0];
    endfunction

endpackage

// File: rtl/iic_reg_seq_ms.sv
// Millisecond timer: loads a ms count and raises done in the last cycle
// of the interval. Comes out of reset already running PRELOAD_MS.
module ms_timer #(
    parameter int unsigned CYC_PER_MS = 10_000,
    parameter int unsigned MS_W       = 16,
    parameter int unsigned PRELOAD_MS = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [MS_W-1:0] ms,
    output logic            running,
    output logic            done
);

    localparam int unsigned    CYC_W    = (CYC_PER_MS > 1) ? $clog2(CYC_PER_MS) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CYC_PER_MS - 1);

    logic [CYC_W-1:0] cyc_cnt;
    logic [MS_W-1:0]  ms_left;

    // done marks the final cycle, so the caller leaves its wait state on
    // the same edge the interval expires.
    assign done = running && (cyc_cnt == '0) && (ms_left == MS_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running <= (PRELOAD_MS != 0);
            ms_left <= MS_W'(PRELOAD_MS);
            cyc_cnt <= CYC_LAST;
        end else if (start) begin
            running <= (ms != '0);
            ms_left <= ms;
            cyc_cnt <= CYC_LAST;
        end else if (running) begin
            if (cyc_cnt == '0) begin
                cyc_cnt <= CYC_LAST;
                ms_left <= ms_left - MS_W'(1);
                if (ms_left == MS_W'(1)) begin
                    running <= 1'b0;
                end
            end else begin
                cyc_cnt <= cyc_cnt - CYC_W'(1);
            end
        end
    end

endmodule

// File: rtl/iic_reg_seq.sv
// Table-driven I2C register sequencer: walks {addr,data} entries, writes each
// through the byte-level I2C driver and optionally reads it back to verify.
module iic_reg_seq
    import iic_reg_seq_pkg::*;
#(
    parameter int unsigned CLK_FRE   = 10_000_000,
    parameter logic [7:0]  DEV_ID    = 8'hB2,
    parameter int unsigned TBL_LEN   = 64,
    parameter int unsigned TBL_AW    = 6,
    parameter int unsigned PWRUP_MS  = 20,
    parameter bit          VERIFY    = 1'b1,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic              clk,
    input  logic              rst,
    output logic [TBL_AW-1:0] tbl_addr,
    input  logic [23:0]       tbl_data,
    output logic [7:0]        device_id,
    output logic              iic_trig,
    output logic              w_r,
    output logic [15:0]       addr,
    output logic [7:0]        data_in,
    input  logic              busy,
    input  logic [7:0]        data_out,
    input  logic              byte_over,
    output logic              init_over,
    output logic              error,
    output logic [TBL_AW-1:0] err_index
);

    localparam int unsigned CYC_PER_MS = CLK_FRE / 1000;
    localparam int unsigned RTY_W      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    seq_state_t state, state_n;

    logic [TBL_AW-1:0] tbl_addr_n, err_index_n;
    logic              iic_trig_n, w_r_n, init_over_n, error_n;
    logic [15:0]       addr_n, ent_addr, ent_addr_n;
    logic [7:0]        data_in_n, ent_data, ent_data_n, rd_data, rd_data_n;
    logic [RTY_W-1:0]  retry, retry_n;
    logic [WDOG_W-1:0] wdog, wdog_n;
    logic              started, started_n, got_byte, got_byte_n;
    logic              fail;

    logic              tmr_start, tmr_running, tmr_done;
    logic [15:0]       dly_ms;

    assign device_id = DEV_ID;
    assign dly_ms    = {8'h00, entry_data(tbl_data)};

    ms_timer #(
        .CYC_PER_MS (CYC_PER_MS),
        .MS_W       (16),
        .PRELOAD_MS (PWRUP_MS)
    ) u_ms_timer (
        .clk     (clk),
        .rst     (rst),
        .start   (tmr_start),
        .ms      (dly_ms),
        .running (tmr_running),
        .done    (tmr_done)
    );

    always_comb begin
        state_n     = state;
        tbl_addr_n  = tbl_addr;
        ent_addr_n  = ent_addr;
        ent_data_n  = ent_data;
        rd_data_n   = rd_data;
        retry_n     = retry;
        wdog_n      = wdog;
        started_n   = started;
        got_byte_n  = got_byte;
        err_index_n = err_index;
        tmr_start   = 1'b0;
        fail        = 1'b0;

        unique case (state)
            ST_PWRUP: begin
                if (tmr_done || !tmr_running) begin
                    state_n = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_n = ST_DECODE;
            end
            ST_DECODE: begin
                ent_addr_n = entry_addr(tbl_data);
                ent_data_n = entry_data(tbl_data);
                if (entry_addr(tbl_data) == DELAY_MARK) begin
                    if (entry_data(tbl_data) == 8'h00) begin
                        state_n = ST_NEXT;
                    end else begin
                        tmr_start = 1'b1;
                        state_n   = ST_DLY;
                    end
                end else begin
                    state_n = ST_WR_TRIG;
                end
            end
            ST_WR_TRIG: begin
                started_n = busy;
                wdog_n    = WDOG_W'(1);
                state_n   = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                if (!started) begin
                    if (busy) begin
                        started_n = 1'b1;
                    end else if (wdog == WDOG_W'(WDOG_CYCLES - 1)) begin
                        fail = 1'b1;
                    end else begin
                        wdog_n = wdog + WDOG_W'(1);
                    end
                end else if (!busy) begin
                    state_n = VERIFY ? ST_RD_TRIG : ST_NEXT;
                end
            end
            ST_RD_TRIG: begin
                started_n  = busy;
                got_byte_n = 1'b0;
                wdog_n     = WDOG_W'(1);
                state_n    = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                // byte_over may coincide with busy falling, so capture it
                // independently of the handshake progress.
                if (byte_over) begin
                    rd_data_n  = data_out;
                    got_byte_n = 1'b1;
                end
                if (!started) begin
                    if (busy) begin
                        started_n = 1'b1;
                    end else if (wdog == WDOG_W'(WDOG_CYCLES - 1)) begin
                        fail = 1'b1;
                    end else begin
                        wdog_n = wdog + WDOG_W'(1);
                    end
                end else if (!busy) begin
                    state_n = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!got_byte || (rd_data != ent_data)) begin
                    fail = 1'b1;
                end else begin
                    state_n = ST_NEXT;
                end
            end
            ST_DLY: begin
                if (tmr_done) begin
                    state_n = ST_NEXT;
                end
            end
            ST_NEXT: begin
                retry_n = '0;
                if (tbl_addr == TBL_AW'(TBL_LEN - 1)) begin
                    state_n = ST_DONE;
                end else begin
                    tbl_addr_n = tbl_addr + TBL_AW'(1);
                    state_n    = ST_FETCH;
                end
            end
            ST_DONE: state_n = ST_DONE;
            ST_ERR:  state_n = ST_ERR;
            default: state_n = ST_PWRUP;
        endcase

        if (fail) begin
            if (retry < RTY_W'(MAX_RETRY)) begin
                retry_n = retry + RTY_W'(1);
                state_n = ST_WR_TRIG;
            end else begin
                err_index_n = tbl_addr;
                state_n     = ST_ERR;
            end
        end

        // Driver-facing outputs are decoded from the next state so they
        // register together with it.
        iic_trig_n  = (state_n == ST_WR_TRIG) || (state_n == ST_RD_TRIG);
        w_r_n       = (state_n == ST_RD_TRIG) ? 1'b0 :
                      (state_n == ST_WR_TRIG) ? 1'b1 : w_r;
        addr_n      = iic_trig_n ? ent_addr_n : addr;
        data_in_n   = (state_n == ST_WR_TRIG) ? ent_data_n : data_in;
        init_over_n = (state_n == ST_DONE);
        error_n     = (state_n == ST_ERR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_PWRUP;
            tbl_addr  <= '0;
            iic_trig  <= 1'b0;
            w_r       <= 1'b1;
            addr      <= '0;
            data_in   <= '0;
            init_over <= 1'b0;
            error     <= 1'b0;
            err_index <= '0;
            ent_addr  <= '0;
            ent_data  <= '0;
            rd_data   <= '0;
            retry     <= '0;
            wdog      <= '0;
            started   <= 1'b0;
            got_byte  <= 1'b0;
        end else begin
            state     <= state_n;
            tbl_addr  <= tbl_addr_n;
            iic_trig  <= iic_trig_n;
            w_r       <= w_r_n;
            addr      <= addr_n;
            data_in   <= data_in_n;
            init_over <= init_over_n;
            error     <= error_n;
            err_index <= err_index_n;
            ent_addr  <= ent_addr_n;
            ent_data  <= ent_data_n;
            rd_data   <= rd_data_n;
            retry     <= retry_n;
            wdog      <= wdog_n;
            started   <= started_n;
            got_byte  <= got_byte_n;
        end
    end

endmodule

// File: tb/tb_iic_reg_seq.sv
// Scoreboard bench: a verify-mode sequencer (dut) against a behavioural I2C
// driver with fault modes, plus a write-only instance (dut_b) on a plain driver.
module tb_iic_reg_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT A: VERIFY=1, 4 entries ----------------
    logic [1:0]  tbl_addr, err_index;
    logic [23:0] tbl_data;
    logic [7:0]  device_id, data_in, data_out;
    logic [15:0] addr;
    logic        iic_trig, w_r, busy, byte_over, init_over, error;

    iic_reg_seq #(
        .CLK_FRE   (10_000),
        .DEV_ID    (8'hB2),
        .TBL_LEN   (4),
        .TBL_AW    (2),
        .PWRUP_MS  (2),
        .VERIFY    (1'b1),
        .MAX_RETRY (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tbl_addr  (tbl_addr),
        .tbl_data  (tbl_data),
        .device_id (device_id),
        .iic_trig  (iic_trig),
        .w_r       (w_r),
        .addr      (addr),
        .data_in   (data_in),
        .busy      (busy),
        .data_out  (data_out),
        .byte_over (byte_over),
        .init_over (init_over),
        .error     (error),
        .err_index (err_index)
    );

    function automatic logic [23:0] rom_a(input logic [1:0] i);
        case (i)
            2'd0:    return 24'hFFFF03;
            2'd1:    return 24'h001234;
            2'd2:    return 24'h100001;
            default: return 24'h00A55A;
        endcase
    endfunction

    always @(posedge clk) tbl_data <= rom_a(tbl_addr);

    // Driver model A
    bit          no_busy   = 1'b0;
    int unsigned bad_reads = 0;
    int unsigned m_cnt, rd_seen;
    logic        m_wr;
    logic [7:0]  last_wr;

    always @(posedge clk) begin
        if (rst) begin
            busy      <= 1'b0;
            byte_over <= 1'b0;
            data_out  <= 8'h00;
            m_cnt     <= 0;
            rd_seen   <= 0;
            m_wr      <= 1'b1;
            last_wr   <= 8'h00;
        end else begin
            byte_over <= 1'b0;
            if (iic_trig && !no_busy) begin
                busy  <= 1'b1;
                m_cnt <= 20;
                m_wr  <= w_r;
                if (w_r) last_wr <= data_in;
            end else if (busy) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    busy <= 1'b0;
                    if (!m_wr) begin
                        byte_over <= 1'b1;
                        data_out  <= (rd_seen < bad_reads) ? 8'h00 : last_wr;
                        rd_seen   <= rd_seen + 1;
                    end
                end
            end
        end
    end

    // ---------------- DUT B: VERIFY=0, 2 entries ----------------
    logic        b_tbl_addr, b_err_index;
    logic [23:0] b_tbl_data;
    logic [7:0]  b_device_id, b_data_in;
    logic [15:0] b_addr;
    logic        b_trig, b_w_r, b_busy, b_init_over, b_error;
    int unsigned b_cnt;

    iic_reg_seq #(
        .CLK_FRE   (10_000),
        .DEV_ID    (8'hB2),
        .TBL_LEN   (2),
        .TBL_AW    (1),
        .PWRUP_MS  (1),
        .VERIFY    (1'b0),
        .MAX_RETRY (3)
    ) dut_b (
        .clk       (clk),
        .rst       (rst),
        .tbl_addr  (b_tbl_addr),
        .tbl_data  (b_tbl_data),
        .device_id (b_device_id),
        .iic_trig  (b_trig),
        .w_r       (b_w_r),
        .addr      (b_addr),
        .data_in   (b_data_in),
        .busy      (b_busy),
        .data_out  (8'h00),
        .byte_over (1'b0),
        .init_over (b_init_over),
        .error     (b_error),
        .err_index (b_err_index)
    );

    always @(posedge clk) b_tbl_data <= b_tbl_addr ? 24'h100001 : 24'h001234;

    always @(posedge clk) begin
        if (rst) begin
            b_busy <= 1'b0;
            b_cnt  <= 0;
        end else if (b_trig) begin
            b_busy <= 1'b1;
            b_cnt  <= 20;
        end else if (b_busy) begin
            b_cnt <= b_cnt - 1;
            if (b_cnt == 1) b_busy <= 1'b0;
        end
    end

    // ---------------- checking ----------------
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    localparam logic [39:0] RST_A = {2'b00, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b0, 2'b00, 8'hB2};

    function automatic logic [39:0] view_a();
        return {tbl_addr, iic_trig, w_r, addr, data_in, init_over, error, err_index, device_id};
    endfunction

    logic [24:0] exp_q[$];
    logic [24:0] b_q[$];
    int rel = 0;

    // Monitor A: scoreboard pops, pulse width, watchdog period, timing marks
    bit have_a1, have_trig, prev_trig;
    int a1_cyc, first_trig, last_trig;

    always @(negedge clk) begin
        logic [24:0] e;
        if (rst) begin
            have_a1   = 1'b0;
            have_trig = 1'b0;
            prev_trig = 1'b0;
        end else begin
            if (!have_a1 && tbl_addr == 2'd1) begin
                have_a1 = 1'b1;
                a1_cyc  = cyc - rel;
            end
            if (iic_trig) begin
                check("trig_width", prev_trig, 1'b0);
                if (no_busy && have_trig) check("wdog_period", cyc - last_trig, 1024);
                if (!have_trig) first_trig = cyc - rel;
                have_trig = 1'b1;
                last_trig = cyc;
                check("trig_pending", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("trig_xfer", {w_r, addr, w_r ? data_in : 8'h00}, e);
                end
            end
            prev_trig = iic_trig;
        end
    end

    always @(negedge clk) begin
        logic [24:0] e;
        if (!rst && b_trig) begin
            check("b_trig_pending", b_q.size() != 0, 1'b1);
            if (b_q.size() != 0) begin
                e = b_q.pop_front();
                check("b_trig_xfer", {b_w_r, b_addr, b_data_in}, e);
            end
        end
    end

    task automatic push_wr(input logic [15:0] a, input logic [7:0] d);
        exp_q.push_back({1'b1, a, d});
    endtask

    task automatic push_pair(input logic [15:0] a, input logic [7:0] d);
        exp_q.push_back({1'b1, a, d});
        exp_q.push_back({1'b0, a, 8'h00});
    endtask

    task automatic start_run(input bit nb, input int unsigned bad);
        rst       = 1'b1;
        no_busy   = nb;
        bad_reads = bad;
        exp_q.delete();
        b_q.delete();
        repeat (3) @(posedge clk);
        #2;
        check("rst_vals", view_a(), RST_A);
        b_q.push_back({1'b1, 16'h0012, 8'h34});
        b_q.push_back({1'b1, 16'h1000, 8'h01});
        @(posedge clk);
        #2;
        rst = 1'b0;
        rel = cyc;
    endtask

    task automatic wait_end(input int unsigned max_cyc);
        int unsigned n = 0;
        while (!(init_over || error) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check("end_reached", init_over | error, 1'b1);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        // Normal run: delay entry, then three verified writes
        start_run(1'b0, 0);
        push_pair(16'h0012, 8'h34);
        push_pair(16'h1000, 8'h01);
        push_pair(16'h00A5, 8'h5A);
        wait_end(3000);
        check("s1_init_over", init_over, 1'b1);
        check("s1_error", error, 1'b0);
        check("s1_sb_drain", exp_q.size(), 0);
        check("s1_fetch1_cycle", a1_cyc, 53);
        check("s1_first_trig_cycle", first_trig, 55);
        check("b_init_over", b_init_over, 1'b1);
        check("b_error", b_error, 1'b0);
        check("b_sb_drain", b_q.size(), 0);

        // Two bad read-backs, third attempt succeeds
        start_run(1'b0, 2);
        push_pair(16'h0012, 8'h34);
        push_pair(16'h0012, 8'h34);
        push_pair(16'h0012, 8'h34);
        push_pair(16'h1000, 8'h01);
        push_pair(16'h00A5, 8'h5A);
        wait_end(3000);
        check("s2_init_over", init_over, 1'b1);
        check("s2_error", error, 1'b0);
        check("s2_sb_drain", exp_q.size(), 0);

        // Read-back always wrong: 1 + MAX_RETRY attempts then error
        start_run(1'b0, 1000);
        for (int i = 0; i < 4; i++) push_pair(16'h0012, 8'h34);
        wait_end(3000);
        check("s3_error", error, 1'b1);
        check("s3_init_over", init_over, 1'b0);
        check("s3_err_index", err_index, 2'd1);
        check("s3_sb_drain", exp_q.size(), 0);

        // Driver never starts: watchdog retriggers then error
        start_run(1'b1, 0);
        for (int i = 0; i < 4; i++) push_wr(16'h0012, 8'h34);
        wait_end(6000);
        check("s4_error", error, 1'b1);
        check("s4_init_over", init_over, 1'b0);
        check("s4_err_index", err_index, 2'd1);
        check("s4_sb_drain", exp_q.size(), 0);

        // Asynchronous reset in the middle of a write
        start_run(1'b0, 0);
        push_pair(16'h0012, 8'h34);
        for (int i = 0; i < 300 && !have_trig; i++) @(negedge clk);
        check("s5_trig_seen", have_trig, 1'b1);
        repeat (5) @(posedge clk);
        #3;
        check("s5_pre_rst", {w_r, addr, data_in}, {1'b1, 16'h0012, 8'h34});
        rst = 1'b1;
        #1;
        check("s5_async_rst", view_a(), RST_A);
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
